// File: rtl/ms_es_sorted_strided_mul_pkg.sv
// Shared types, constant helpers and parameter legality rules for the
// sorted, strided deterministic stochastic multiplier.
package ms_es_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Upper bound on AND terms evaluated per RUN cycle.
  localparam int unsigned MAX_LANES = 64;

  // Ceiling log2, with a floor of 1 bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

  // Integer power b**e.
  function automatic int unsigned ipow(input int unsigned b, input int unsigned e);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  // LANES = STRIDE**NUM_INPUTS: AND terms evaluated per RUN cycle.
  function automatic int unsigned lanes_of(input int unsigned stride, input int unsigned n);
    return ipow(stride, n);
  endfunction

  // Last value taken by a lane counter before it wraps.
  function automatic int unsigned max_count(input int unsigned dw, input int unsigned stride);
    return ipow(2, dw) - stride;
  endfunction

  // Parameter legality: operand count, power-of-two stride, lane budget.
  function automatic bit params_legal(input int unsigned dw, input int unsigned n,
                                      input int unsigned stride);
    bit ok;
    ok = 1'b1;
    if (dw < 1 || dw > 16) ok = 1'b0;
    if (n < 2 || n > 5) ok = 1'b0;
    if (stride == 0 || (stride & (stride - 1)) != 0) ok = 1'b0;
    if (stride > ipow(2, dw)) ok = 1'b0;
    if (ipow(stride, n) > MAX_LANES) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/ms_es_sorted_strided_mul_lanes.sv
// One operand slot: strided unary counter plus STRIDE comparator lanes.
module sng_strided_lanes
  import ms_es_mul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned STRIDE     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] value,
  output logic [STRIDE-1:0]     lanes,
  output logic                  at_max
);

  localparam int unsigned MAX_CNT = max_count(DATA_WIDTH, STRIDE);
  localparam int unsigned XW      = DATA_WIDTH + 1;

  logic [DATA_WIDTH-1:0] cnt;

  assign at_max = (cnt == DATA_WIDTH'(MAX_CNT));

  // Counter advances by STRIDE and wraps to zero after its last position.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= at_max ? '0 : cnt + DATA_WIDTH'(STRIDE);
    end
  end

  // Lane k is high while (cnt + k) is below the operand value.
  always_comb begin
    lanes = '0;
    for (int unsigned k = 0; k < STRIDE; k++) begin
      lanes[k] = (XW'(cnt) + XW'(k)) < XW'(value);
    end
  end

endmodule

// File: rtl/ms_es_sorted_strided_mul.sv
// Sorted, strided deterministic stochastic multiplier: captures NUM_INPUTS
// operands, sorts them descending, then counts AND-ed unary lane
// combinations into an exact binary product.
module ms_es_sorted_strided_mul
  import ms_es_mul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned STRIDE     = 4,
  parameter int unsigned CW         = DATA_WIDTH * NUM_INPUTS + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_in,
  input  logic                             early_term_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*NUM_INPUTS-1:0] bin_data_out,
  output logic [CW-1:0]                    run_cycles,
  output logic                             busy
);

  localparam int unsigned AW    = DATA_WIDTH * NUM_INPUTS;
  localparam int unsigned LANES = lanes_of(STRIDE, NUM_INPUTS);
  localparam int unsigned PW    = clog2(LANES + 1);
  localparam int unsigned SCW   = clog2(NUM_INPUTS);

  if (!params_legal(DATA_WIDTH, NUM_INPUTS, STRIDE)) begin : g_param_check
    $error("ms_es_sorted_strided_mul: illegal DATA_WIDTH/NUM_INPUTS/STRIDE combination");
  end

  state_e state, state_next;

  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] slot, slot_swapped;
  logic                                  early_q;
  logic [SCW-1:0]                        sort_cnt;
  logic [AW-1:0]                         acc, acc_sum;
  logic [CW-1:0]                         run_cnt;
  logic [NUM_INPUTS-1:0][STRIDE-1:0]     lanes_all;
  logic [NUM_INPUTS-1:0]                 at_max, step;
  logic [LANES-1:0]                      terms;
  logic [PW-1:0]                         pop;
  logic latch, sort_en, run_en, acc_en, finish;
  logic all_max, exit_early;

  // Per-slot strided lane generators.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_slot
    sng_strided_lanes #(
      .DATA_WIDTH(DATA_WIDTH),
      .STRIDE    (STRIDE)
    ) u_lanes (
      .clk   (clk),
      .rst   (rst),
      .clr   (latch),
      .step  (step[i]),
      .value (slot[i]),
      .lanes (lanes_all[i]),
      .at_max(at_max[i])
    );
  end

  // Nested-counter enables: slot i steps only when all lower slots are at max.
  always_comb begin
    logic chain;
    chain = run_en;
    step  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      step[i] = chain;
      chain   = chain && at_max[i];
    end
  end

  assign all_max    = &at_max;
  assign exit_early = early_q && !lanes_all[NUM_INPUTS-1][0];

  // AND matrix: term t picks lane k_i = digit i of t in base STRIDE.
  for (genvar t = 0; t < LANES; t++) begin : g_term
    logic [NUM_INPUTS-1:0] sel;
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_op
      localparam int unsigned K = (32'(t) / ipow(STRIDE, 32'(i))) % STRIDE;
      assign sel[i] = lanes_all[i][K];
    end
    assign terms[t] = &sel;
  end

  assign pop     = PW'($countones(terms));
  assign acc_sum = acc + AW'(pop);

  // Odd-even transposition step; equal values never swap.
  always_comb begin
    slot_swapped = slot;
    for (int j = 0; j < NUM_INPUTS - 1; j++) begin
      if ((j[0] == sort_cnt[0]) && (slot[j] < slot[j+1])) begin
        slot_swapped[j]   = slot[j+1];
        slot_swapped[j+1] = slot[j];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and datapath control.
  always_comb begin
    state_next = state;
    latch      = 1'b0;
    sort_en    = 1'b0;
    run_en     = 1'b0;
    acc_en     = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          latch      = 1'b1;
          state_next = SORT;
        end
      end
      SORT: begin
        sort_en = 1'b1;
        if (sort_cnt == SCW'(NUM_INPUTS - 1)) state_next = RUN;
      end
      RUN: begin
        run_en = 1'b1;
        if (exit_early) begin
          finish     = 1'b1;
          state_next = DONE;
        end else begin
          acc_en = 1'b1;
          if (all_max) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (out_valid && out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand slots, sort counter, accumulator and run counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= '0;
      early_q  <= 1'b0;
      sort_cnt <= '0;
      acc      <= '0;
      run_cnt  <= '0;
    end else begin
      if (latch) begin
        slot     <= bin_data_in;
        early_q  <= early_term_en;
        sort_cnt <= '0;
        acc      <= '0;
        run_cnt  <= '0;
      end
      if (sort_en) begin
        slot     <= slot_swapped;
        sort_cnt <= sort_cnt + SCW'(1);
      end
      if (acc_en) acc <= acc_sum;
      if (run_en) run_cnt <= run_cnt + CW'(1);
    end
  end

  // Registered status and result outputs; result held until the next finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready     <= 1'b1;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      bin_data_out <= '0;
      run_cycles   <= '0;
    end else begin
      in_ready  <= (state_next == IDLE);
      busy      <= (state_next == SORT) || (state_next == RUN);
      out_valid <= (state_next == DONE);
      if (finish) begin
        bin_data_out <= acc_en ? acc_sum : acc;
        run_cycles   <= run_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ms_es_sorted_strided_mul.sv
// Self-checking bench: three configurations against a product/cycle model.
module tb_ms_es_sorted_strided_mul;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Config A: DW=4, STRIDE=4, N=2
  logic       a_iv, a_ir, a_e, a_ov, a_or, a_busy;
  logic [7:0] a_din, a_dout;
  logic [8:0] a_cyc;
  // Config B: DW=4, STRIDE=2, N=3
  logic        b_iv, b_ir, b_e, b_ov, b_or, b_busy;
  logic [11:0] b_din, b_dout;
  logic [12:0] b_cyc;
  // Config C: defaults DW=5, STRIDE=4, N=2
  logic        c_iv, c_ir, c_e, c_ov, c_or, c_busy;
  logic [9:0]  c_din, c_dout;
  logic [10:0] c_cyc;

  int perms [6][3] = '{'{0,1,2}, '{0,2,1}, '{1,0,2}, '{1,2,0}, '{2,0,1}, '{2,1,0}};

  ms_es_sorted_strided_mul #(.DATA_WIDTH(4), .NUM_INPUTS(2), .STRIDE(4), .CW(9)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .bin_data_in(a_din),
    .early_term_en(a_e), .out_valid(a_ov), .out_ready(a_or), .bin_data_out(a_dout),
    .run_cycles(a_cyc), .busy(a_busy));

  ms_es_sorted_strided_mul #(.DATA_WIDTH(4), .NUM_INPUTS(3), .STRIDE(2), .CW(13)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .bin_data_in(b_din),
    .early_term_en(b_e), .out_valid(b_ov), .out_ready(b_or), .bin_data_out(b_dout),
    .run_cycles(b_cyc), .busy(b_busy));

  ms_es_sorted_strided_mul u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .bin_data_in(c_din),
    .early_term_en(c_e), .out_valid(c_ov), .out_ready(c_or), .bin_data_out(c_dout),
    .run_cycles(c_cyc), .busy(c_busy));

  // Reference model: plain product of the operands.
  function automatic int ref_prod(input logic [31:0] ops, input int dw, input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * int'((ops >> (i * dw)) & ((32'd1 << dw) - 32'd1));
    return p;
  endfunction

  function automatic int ref_min(input logic [31:0] ops, input int dw, input int n);
    int m;
    int v;
    m = 1 << dw;
    for (int i = 0; i < n; i++) begin
      v = int'((ops >> (i * dw)) & ((32'd1 << dw) - 32'd1));
      if (v < m) m = v;
    end
    return m;
  endfunction

  // RUN cycles: full sweep, or stop once the slowest counter reaches the minimum.
  function automatic int ref_cycles(input int dw, input int s, input int n, input int m, input bit e);
    int p, full, blk;
    p    = (1 << dw) / s;
    full = 1;
    for (int i = 0; i < n; i++) full = full * p;
    if (!e) return full;
    blk = (m + s - 1) / s;
    if (blk >= p) return full;
    return blk * (full / p) + 1;
  endfunction

  task automatic op_a(input logic [7:0] d, input bit e, output int res, output int cyc, output bit to);
    int n;
    @(negedge clk); a_din = d; a_e = e; a_iv = 1'b1;
    @(negedge clk); a_iv = 1'b0;
    n = 0;
    while (!a_ov && n < 700) begin @(negedge clk); n++; end
    to = !a_ov; res = int'(a_dout); cyc = int'(a_cyc);
    a_or = 1'b1; @(negedge clk); a_or = 1'b0;
  endtask

  task automatic op_b(input logic [11:0] d, input bit e, output int res, output int cyc, output bit to);
    int n;
    @(negedge clk); b_din = d; b_e = e; b_iv = 1'b1;
    @(negedge clk); b_iv = 1'b0;
    n = 0;
    while (!b_ov && n < 700) begin @(negedge clk); n++; end
    to = !b_ov; res = int'(b_dout); cyc = int'(b_cyc);
    b_or = 1'b1; @(negedge clk); b_or = 1'b0;
  endtask

  task automatic start_c(input logic [9:0] d, input bit e);
    @(negedge clk); c_din = d; c_e = e; c_iv = 1'b1;
    @(negedge clk); c_iv = 1'b0;
  endtask

  // Waits for out_valid; optionally throws ignored in_valid pulses while busy.
  task automatic wait_c(input bit noise, output bit to);
    int n;
    n = 0;
    while (!c_ov && n < 700) begin
      if (noise) begin
        c_iv  = 1'($urandom_range(0, 1));
        c_din = 10'($urandom);
        c_e   = 1'($urandom_range(0, 1));
      end
      @(negedge clk); n++;
    end
    c_iv = 1'b0;
    to = !c_ov;
  endtask

  task automatic accept_c();
    c_or = 1'b1; @(negedge clk); c_or = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (c_ov !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0d want 0", c_ov); end
    total++; if (c_dout !== 10'd0) begin bad++; $display("FAIL rst_data: got %0d want 0", c_dout); end
    total++; if (c_cyc !== 11'd0) begin bad++; $display("FAIL rst_cycles: got %0d want 0", c_cyc); end
    total++; if (c_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0d want 0", c_busy); end
    total++; if (c_ir !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %0d want 1", c_ir); end
    total++; if (a_ir !== 1'b1 || b_ir !== 1'b1) begin
      bad++; $display("FAIL rst_in_ready_ab: got %0d/%0d want 1/1", a_ir, b_ir);
    end
  endtask

  task automatic test_early_exit();
    int res, cyc;
    bit to;
    op_a({4'd3, 4'd5}, 1'b1, res, cyc, to);
    total++; if (to) begin bad++; $display("FAIL a_early_timeout: got timeout want out_valid"); end
    total++; if (res !== 15) begin bad++; $display("FAIL a_early_prod: got %0d want 15", res); end
    total++; if (cyc !== 5) begin bad++; $display("FAIL a_early_cycles: got %0d want 5", cyc); end
    op_a({4'd3, 4'd5}, 1'b0, res, cyc, to);
    total++; if (to) begin bad++; $display("FAIL a_full_timeout: got timeout want out_valid"); end
    total++; if (res !== 15) begin bad++; $display("FAIL a_full_prod: got %0d want 15", res); end
    total++; if (cyc !== 16) begin bad++; $display("FAIL a_full_cycles: got %0d want 16", cyc); end
  endtask

  task automatic test_zero_operand();
    int res, cyc;
    bit to;
    op_b({4'd7, 4'd15, 4'd0}, 1'b1, res, cyc, to);
    total++; if (to) begin bad++; $display("FAIL b_zero_early_timeout: got timeout want out_valid"); end
    total++; if (res !== 0) begin bad++; $display("FAIL b_zero_early_prod: got %0d want 0", res); end
    total++; if (cyc !== 1) begin bad++; $display("FAIL b_zero_early_cycles: got %0d want 1", cyc); end
    op_b({4'd7, 4'd15, 4'd0}, 1'b0, res, cyc, to);
    total++; if (to) begin bad++; $display("FAIL b_zero_full_timeout: got timeout want out_valid"); end
    total++; if (res !== 0) begin bad++; $display("FAIL b_zero_full_prod: got %0d want 0", res); end
    total++; if (cyc !== 512) begin bad++; $display("FAIL b_zero_full_cycles: got %0d want 512", cyc); end
  endtask

  task automatic test_hold();
    bit to;
    start_c({5'd31, 5'd31}, 1'b1);
    wait_c(1'b0, to);
    total++; if (to) begin bad++; $display("FAIL c_hold_timeout: got timeout want out_valid"); end
    total++; if (c_dout !== 10'd961) begin bad++; $display("FAIL c_max_prod: got %0d want 961", c_dout); end
    total++; if (c_cyc !== 11'd64) begin bad++; $display("FAIL c_max_cycles: got %0d want 64", c_cyc); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (c_ov !== 1'b1 || c_dout !== 10'd961 || c_cyc !== 11'd64 || c_ir !== 1'b0) begin
        bad++;
        $display("FAIL c_hold_stable: got ov=%0d d=%0d cyc=%0d ir=%0d want 1/961/64/0",
                 c_ov, c_dout, c_cyc, c_ir);
      end
    end
    accept_c();
    total++; if (c_ov !== 1'b0 || c_ir !== 1'b1) begin
      bad++; $display("FAIL c_after_accept: got ov=%0d ir=%0d want 0/1", c_ov, c_ir);
    end
    total++; if (c_dout !== 10'd961) begin bad++; $display("FAIL c_data_kept: got %0d want 961", c_dout); end
  endtask

  task automatic test_reset_mid_run();
    bit to;
    start_c({5'd31, 5'd31}, 1'b0);
    repeat (20) @(negedge clk);
    total++; if (c_busy !== 1'b1) begin bad++; $display("FAIL c_busy_run: got %0d want 1", c_busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (c_ov !== 1'b0 || c_ir !== 1'b1 || c_busy !== 1'b0) begin
      bad++; $display("FAIL c_mid_reset_ctl: got ov=%0d ir=%0d busy=%0d want 0/1/0", c_ov, c_ir, c_busy);
    end
    total++; if (c_dout !== 10'd0) begin bad++; $display("FAIL c_mid_reset_data: got %0d want 0", c_dout); end
    start_c({5'd2, 5'd2}, 1'b1);
    wait_c(1'b0, to);
    total++; if (to) begin bad++; $display("FAIL c_after_reset_timeout: got timeout want out_valid"); end
    total++; if (c_dout !== 10'd4) begin bad++; $display("FAIL c_after_reset_prod: got %0d want 4", c_dout); end
    total++; if (int'(c_cyc) !== ref_cycles(5, 4, 2, 2, 1'b1)) begin
      bad++; $display("FAIL c_after_reset_cycles: got %0d want %0d", c_cyc, ref_cycles(5, 4, 2, 2, 1'b1));
    end
    accept_c();
  endtask

  task automatic test_random_sweep();
    for (int it = 0; it < 20; it++) begin
      logic [4:0] x0, x1;
      logic [9:0] d;
      bit e, to;
      int exp_p, exp_c;
      x0 = 5'($urandom);
      x1 = (it % 4 == 0) ? x0 : 5'($urandom);
      if (it % 5 == 1) x1 = 5'd0;
      e = 1'($urandom_range(0, 1));
      d = {x1, x0};
      exp_p = ref_prod(32'(d), 5, 2);
      exp_c = ref_cycles(5, 4, 2, ref_min(32'(d), 5, 2), e);
      start_c(d, e);
      wait_c(1'b1, to);
      total++; if (to) begin bad++; $display("FAIL c_rand_timeout: ops=%0d,%0d got timeout", x0, x1); end
      total++; if (int'(c_dout) !== exp_p) begin
        bad++; $display("FAIL c_rand_prod: ops=%0d,%0d got %0d want %0d", x0, x1, c_dout, exp_p);
      end
      total++; if (int'(c_cyc) !== exp_c) begin
        bad++; $display("FAIL c_rand_cycles: ops=%0d,%0d e=%0d got %0d want %0d", x0, x1, e, c_cyc, exp_c);
      end
      accept_c();
    end
  endtask

  task automatic test_permutations();
    for (int set = 0; set < 4; set++) begin
      logic [3:0]  v [3];
      logic [11:0] d;
      int res, cyc, exp_p, exp_c;
      bit e, to;
      v[0] = 4'($urandom);
      v[1] = (set == 1) ? v[0] : 4'($urandom);
      v[2] = (set == 2) ? 4'd0 : ((set == 3) ? v[1] : 4'($urandom));
      for (int p = 0; p < 6; p++) begin
        d = {v[perms[p][2]], v[perms[p][1]], v[perms[p][0]]};
        e = 1'($urandom_range(0, 1));
        exp_p = ref_prod(32'(d), 4, 3);
        exp_c = ref_cycles(4, 2, 3, ref_min(32'(d), 4, 3), e);
        op_b(d, e, res, cyc, to);
        total++; if (to) begin bad++; $display("FAIL b_perm_timeout: ops=%03h got timeout", d); end
        total++; if (res !== exp_p) begin
          bad++; $display("FAIL b_perm_prod: ops=%03h got %0d want %0d", d, res, exp_p);
        end
        total++; if (cyc !== exp_c) begin
          bad++; $display("FAIL b_perm_cycles: ops=%03h e=%0d got %0d want %0d", d, e, cyc, exp_c);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 8; it++) begin
      logic [7:0] d;
      int res, cyc, exp_p, exp_c;
      bit e, to;
      d = 8'($urandom);
      e = 1'(it % 2);
      exp_p = ref_prod(32'(d), 4, 2);
      exp_c = ref_cycles(4, 4, 2, ref_min(32'(d), 4, 2), e);
      op_a(d, e, res, cyc, to);
      total++; if (to) begin bad++; $display("FAIL a_b2b_timeout: ops=%02h got timeout", d); end
      total++; if (res !== exp_p) begin
        bad++; $display("FAIL a_b2b_prod: ops=%02h got %0d want %0d", d, res, exp_p);
      end
      total++; if (cyc !== exp_c) begin
        bad++; $display("FAIL a_b2b_cycles: ops=%02h e=%0d got %0d want %0d", d, e, cyc, exp_c);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    a_iv = 1'b0; a_e = 1'b0; a_or = 1'b0; a_din = '0;
    b_iv = 1'b0; b_e = 1'b0; b_or = 1'b0; b_din = '0;
    c_iv = 1'b0; c_e = 1'b0; c_or = 1'b0; c_din = '0;
    test_reset();
    test_early_exit();
    test_zero_operand();
    test_hold();
    test_reset_mid_run();
    test_random_sweep();
    test_permutations();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ms_es_sorted_strided_mul.md
Name: ms_es_sorted_strided_mul

Overview:
- Single-clock, parametrised successor to the per-input ripple-clocked deterministic stochastic multiplier.
- Accepts NUM_INPUTS unsigned operands and sorts them sequentially into descending order.
- Generates STRIDE unary lanes per operand using nested counters enabled from one clock, ANDs every lane combination, and accumulates the popcount into an exact binary product.
- Adds an in/out valid-ready handshake, optional early termination and a cycle-count statistic for the arch sweep.

Parameters:
- DATA_WIDTH, 5: operand width in bits.
- NUM_INPUTS, 2: operand count, 2..5.
- STRIDE, 4: unary lanes per operand per cycle. Power of two, at most 2**DATA_WIDTH. STRIDE**NUM_INPUTS must be at most 64.
- CW, DATA_WIDTH*NUM_INPUTS+1: width of run_cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set offered.
- in_ready  out  1  high only in IDLE.
- bin_data_in  in  NUM_INPUTS*DATA_WIDTH  packed operands; operand i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- early_term_en  in  1  sampled with the operands; enables early exit.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- bin_data_out  out  DATA_WIDTH*NUM_INPUTS  product of the operands.
- run_cycles  out  CW  number of RUN-state cycles used for this result.
- busy  out  1  high in SORT or RUN.

Behaviour:
- Reset: state goes to IDLE. out_valid=0, bin_data_out=0, run_cycles=0, busy=0, in_ready=1. All counters, the accumulator and operand registers are cleared.
- Reset mid-operation aborts the current operation; no result is produced.

FSM states: IDLE, SORT, RUN, DONE.
- IDLE:
  - in_valid&&in_ready latches the operands and early_term_en.
  - Clears the accumulator, run counter and all lane counters.
  - Goes to SORT.
- SORT: odd-even transposition sort, exactly NUM_INPUTS cycles.
  - Even cycles compare pairs (0,1),(2,3)…; odd cycles compare (1,2),(3,4)….
  - A pair swaps only if slot[j] < slot[j+1], so equal values never swap.
  - Result: slot0 = max, slot NUM_INPUTS-1 (outermost) = min.
  - Then goes to RUN.
- RUN: each slot i has a counter c_i stepping by STRIDE, from 0 to 2**DATA_WIDTH-STRIDE.
  - Lane k of slot i = (c_i + k) < slot_i.
  - c_0 steps every RUN cycle. c_i steps only when all lower counters are at max; those lower counters wrap to 0.
  - Early exit: if early_term_en and outermost lane0 == 0, go to DONE this cycle without accumulating. This cycle still counts in run_cycles.
  - Otherwise acc += popcount of the STRIDE**NUM_INPUTS AND-terms. Terms are indexed by {k_(N-1),…,k_0}, with k_0 least significant.
  - After accumulating in the final combination (all counters at max), go to DONE.
  - run_cycles increments on every RUN cycle.
  - Full-length run takes (2**DATA_WIDTH/STRIDE)**NUM_INPUTS cycles.
- DONE:
  - out_valid=1, with bin_data_out=acc and run_cycles held stable.
  - On out_valid&&out_ready, go to IDLE; out_valid drops the next cycle.
  - bin_data_out and run_cycles keep their values until the next accept.

Width, ordering and handshake rules:
- The accumulator is DATA_WIDTH*NUM_INPUTS bits. The maximum product (2**DW-1)**N fits, so overflow is impossible.
- Any zero operand sorts outermost. With early_term_en set, it exits after exactly 1 RUN cycle with result 0.
- in_valid outside IDLE is ignored; no queuing.
- Operands change no state after capture. The result is independent of input ordering and of early_term_en; only run_cycles differs.
- out_ready while not DONE has no effect.

Decomposition:
- Package ms_es_mul_pkg holds:
  - state enum (IDLE/SORT/RUN/DONE);
  - the clog2 function;
  - LANES = STRIDE**NUM_INPUTS;
  - a max-count constant;
  - elaboration-time parameter legality checks.
- Sub-module sng_strided_lanes (one instance per slot):
  - contents: counter, step enable, wrap flag and STRIDE comparator lanes;
  - ports: clk, rst, clr, step, value, lanes, at_max.
- The top level holds the FSM, sorter, AND matrix, popcount and accumulator.

Test Plan:
1. DW=4, STRIDE=4, N=2; operands {5,3}, early on.
   - Sorted to slot0=5, slot1=3.
   - Expect out_valid with bin_data_out=15 and run_cycles=5.
2. Same operands, early off.
   - Expect bin_data_out=15, run_cycles=16.
3. DW=4, STRIDE=2, N=3; operands {0,15,7}, early on.
   - Expect bin_data_out=0, run_cycles=1.
   - With early off, expect bin_data_out=0, run_cycles=512.
4. Defaults (DW=5, STRIDE=4, N=2); operands {31,31}, early on.
   - Expect bin_data_out=961, run_cycles=64.
   - Hold out_ready=0 for 10 cycles: outputs stay stable and in_ready stays 0.
5. Assert rst during RUN.
   - Next cycle: IDLE, out_valid=0, bin_data_out=0, in_ready=1.
   - New operands {2,2} then give bin_data_out=4.
6. Random sweep against a reference product, including duplicate operands and permutations.
   - All permutations give an identical bin_data_out.
   - in_valid pulses during busy are ignored.
